// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and
// a width helper used to size the counters from their terminal counts.
package pll_seq_pkg;

    localparam logic [2:0] HOLD_PLL  = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] SETTLE    = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] FAULT     = 3'd4;

    typedef enum logic [2:0] {
        ST_HOLD_PLL  = HOLD_PLL,
        ST_WAIT_LOCK = WAIT_LOCK,
        ST_SETTLE    = SETTLE,
        ST_RUN       = RUN,
        ST_FAULT     = FAULT
    } seq_state_e;

    // Ceiling log2; callers pass (terminal count + 1) so the result is >= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the sequencer, the iCE40 PLL and the reset consumers.
// There is no valid/ready handshake on this bundle: pll_lock is a level from
// the PLL and every output is a registered level that holds until the state
// machine changes it.
interface pll_reset_sequencer_if #(
    parameter int RW = 2
);
    logic          pll_lock;
    logic          pll_resetb;
    logic          sys_resetn;
    logic          locked;
    logic          fault;
    logic [RW-1:0] retry_count;
    logic [3:0]    loss_count;

    // Sequencer side.
    modport master (
        input  pll_lock,
        output pll_resetb, sys_resetn, locked, fault, retry_count, loss_count
    );

    // PLL / reset-consumer side.
    modport slave (
        output pll_lock,
        input  pll_resetb, sys_resetn, locked, fault, retry_count, loss_count
    );
endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low reset. Used for PLL LOCK
// here and for SYS_RESETN in the 64 MHz domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // Two-stage capture of the asynchronous input; both stages clear to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the iCE40 PLL out of reset, filters its LOCK output, holds the
// system in reset until lock has settled, and re-sequences or retries on
// lock loss / lock timeout. Outputs are registered from the next state so
// they change on the same edge as the state and never glitch.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int POR_CYCLES    = 16,
    parameter int LOCK_FILTER   = 64,
    parameter int LOCK_TIMEOUT  = 16384,
    parameter int SETTLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                   referenceclk,
    input  logic                   reset,
    pll_reset_sequencer_if.master  bus,
    output logic [2:0]             state_dbg
);
    // One shared counter serves HOLD_PLL, WAIT_LOCK (timeout) and SETTLE.
    localparam int CNT_MAX = (LOCK_TIMEOUT > SETTLE_CYCLES)
                           ? ((LOCK_TIMEOUT > POR_CYCLES) ? LOCK_TIMEOUT : POR_CYCLES)
                           : ((SETTLE_CYCLES > POR_CYCLES) ? SETTLE_CYCLES : POR_CYCLES);
    localparam int CW = clog2(CNT_MAX + 1);
    localparam int FW = clog2(LOCK_FILTER + 1);
    localparam int RW = clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] POR_LAST    = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_DONE    = CW'(LOCK_TIMEOUT);
    localparam logic [FW-1:0] FILT_DONE   = FW'(LOCK_FILTER);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] filt_q, filt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [3:0]    loss_q, loss_d;
    logic          pll_resetb_q, sys_resetn_q, locked_q, fault_q;
    logic          lock_s;

    sync_2ff u_lock_sync (
        .clk   (referenceclk),
        .rst_n (reset),
        .d     (bus.pll_lock),
        .q     (lock_s)
    );

    // State, counters and decoded outputs; reset forces the safe output levels at once.
    always_ff @(posedge referenceclk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HOLD_PLL;
            cnt_q        <= '0;
            filt_q       <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            pll_resetb_q <= 1'b0;
            sys_resetn_q <= 1'b0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            filt_q       <= filt_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            pll_resetb_q <= (state_d == ST_WAIT_LOCK) || (state_d == ST_SETTLE) ||
                            (state_d == ST_RUN);
            sys_resetn_q <= (state_d == ST_RUN);
            locked_q     <= (state_d == ST_SETTLE) || (state_d == ST_RUN);
            fault_q      <= (state_d == ST_FAULT);
        end
    end

    // Next-state and counter updates; any state change restarts cnt and filt.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        unique case (state_q)
            ST_HOLD_PLL: begin
                if (cnt_q == POR_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                cnt_d  = cnt_q + 1'b1;
                filt_d = lock_s ? filt_q + 1'b1 : '0;
                // An accepted lock wins over a timeout landing on the same edge.
                if (filt_q == FILT_DONE) begin
                    state_d = ST_SETTLE;
                end else if (cnt_q == TMO_DONE) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_FAULT;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_HOLD_PLL;
                    end
                end
            end

            ST_SETTLE: begin
                if (!lock_s) begin
                    state_d = ST_HOLD_PLL;
                    if (loss_q != 4'd15) loss_d = loss_q + 4'd1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_HOLD_PLL;
                    if (loss_q != 4'd15) loss_d = loss_q + 4'd1;
                end
            end

            ST_FAULT: begin
                state_d = ST_FAULT;
            end

            default: begin
                state_d = ST_HOLD_PLL;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d  = '0;
            filt_d = '0;
        end
    end

    assign bus.pll_resetb  = pll_resetb_q;
    assign bus.sys_resetn  = sys_resetn_q;
    assign bus.locked      = locked_q;
    assign bus.fault       = fault_q;
    assign bus.retry_count = retry_q;
    assign bus.loss_count  = loss_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters.
// Cycle numbers count rising edges after reset release; a vector's expected
// value is the output bundle just after that edge, and its lock value is
// applied after that edge.
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    localparam int RW = 2;
    localparam int W  = 14;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] state_dbg;

    pll_reset_sequencer_if #(.RW(RW)) bus();

    pll_reset_sequencer #(
        .POR_CYCLES    (4),
        .LOCK_FILTER   (8),
        .LOCK_TIMEOUT  (100),
        .SETTLE_CYCLES (16),
        .MAX_RETRIES   (2)
    ) dut (
        .referenceclk (clk),
        .reset        (rst_n),
        .bus          (bus),
        .state_dbg    (state_dbg)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic         lock_next;
        logic [W-1:0] exp;
    } vec_t;

    vec_t         tbl[$];
    logic [W-1:0] exp_q[$];
    int           cyc;
    int           n_checks;
    int           n_pass;

    // Expected bundle layout: {state, pll_resetb, sys_resetn, locked, fault, retry, loss}.
    function automatic logic [W-1:0] pack(input logic [2:0] st, input logic rb, input logic sn,
                                          input logic lk, input logic ft,
                                          input logic [1:0] rc, input logic [3:0] lc);
        return {st, rb, sn, lk, ft, rc, lc};
    endfunction

    function automatic logic [W-1:0] obs();
        return {state_dbg, bus.pll_resetb, bus.sys_resetn, bus.locked, bus.fault,
                bus.retry_count, bus.loss_count};
    endfunction

    task automatic add(input int c, input logic ln, input logic [2:0] st, input logic rb,
                       input logic sn, input logic lk, input logic ft,
                       input logic [1:0] rc, input logic [3:0] lc);
        vec_t v;
        v.cyc       = c;
        v.lock_next = ln;
        v.exp       = pack(st, rb, sn, lk, ft, rc, lc);
        tbl.push_back(v);
    endtask

    // Scoreboard: compare the observed bundle to the oldest expected entry.
    task automatic check(input string name, input logic [W-1:0] act);
        logic [W-1:0] exp;
        exp = exp_q.pop_front();
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got {st,rb,sn,lk,ft,rc,lc}=%b expected %b", name, act, exp);
        end
    endtask

    // Advance to just after rising edge e (cycle numbers relative to reset release).
    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic do_reset(input logic lock0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.pll_lock = lock0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) exp_q.push_back(tbl[i].exp);
        for (int i = 0; i < tbl.size(); i++) begin
            goto(tbl[i].cyc);
            check($sformatf("%s@%0d", tag, cyc), obs());
            bus.pll_lock = tbl[i].lock_next;
        end
        tbl.delete();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        bus.pll_lock = 1'b0;

        // Nominal bring-up, then a 20-cycle lock loss in RUN and re-sequence.
        do_reset(1'b0);
        add(0,  0, HOLD_PLL,  0, 0, 0, 0, 2'd0, 4'd0);
        add(3,  0, HOLD_PLL,  0, 0, 0, 0, 2'd0, 4'd0);
        add(4,  0, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(10, 1, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(20, 1, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(21, 1, SETTLE,    1, 0, 1, 0, 2'd0, 4'd0);
        add(36, 1, SETTLE,    1, 0, 1, 0, 2'd0, 4'd0);
        add(37, 1, RUN,       1, 1, 1, 0, 2'd0, 4'd0);
        add(50, 0, RUN,       1, 1, 1, 0, 2'd0, 4'd0);
        add(52, 0, RUN,       1, 1, 1, 0, 2'd0, 4'd0);
        add(53, 0, HOLD_PLL,  0, 0, 0, 0, 2'd0, 4'd1);
        add(56, 0, HOLD_PLL,  0, 0, 0, 0, 2'd0, 4'd1);
        add(57, 0, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd1);
        add(70, 1, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd1);
        add(80, 1, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd1);
        add(81, 1, SETTLE,    1, 0, 1, 0, 2'd0, 4'd1);
        add(96, 1, SETTLE,    1, 0, 1, 0, 2'd0, 4'd1);
        add(97, 1, RUN,       1, 1, 1, 0, 2'd0, 4'd1);
        run_table("nominal_loss");

        // One-cycle lock glitch while filt=5: filter restarts, RUN arrives 8 edges late.
        do_reset(1'b0);
        add(4,  0, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(10, 1, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(17, 0, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(18, 1, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(28, 1, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(29, 1, SETTLE,    1, 0, 1, 0, 2'd0, 4'd0);
        add(44, 1, SETTLE,    1, 0, 1, 0, 2'd0, 4'd0);
        add(45, 1, RUN,       1, 1, 1, 0, 2'd0, 4'd0);
        run_table("glitch");

        // Timeout exactly on the edge the filter completes: lock wins.
        do_reset(1'b0);
        add(4,   0, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(94,  1, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(104, 1, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(105, 1, SETTLE,    1, 0, 1, 0, 2'd0, 4'd0);
        add(120, 1, SETTLE,    1, 0, 1, 0, 2'd0, 4'd0);
        add(121, 1, RUN,       1, 1, 1, 0, 2'd0, 4'd0);
        run_table("tie");

        // One timeout, then lock: RETRY_COUNT held through SETTLE, cleared on RUN entry.
        do_reset(1'b0);
        add(104, 0, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(105, 0, HOLD_PLL,  0, 0, 0, 0, 2'd1, 4'd0);
        add(109, 1, WAIT_LOCK, 1, 0, 0, 0, 2'd1, 4'd0);
        add(119, 1, WAIT_LOCK, 1, 0, 0, 0, 2'd1, 4'd0);
        add(120, 1, SETTLE,    1, 0, 1, 0, 2'd1, 4'd0);
        add(135, 1, SETTLE,    1, 0, 1, 0, 2'd1, 4'd0);
        add(136, 1, RUN,       1, 1, 1, 0, 2'd0, 4'd0);
        run_table("retry_clear");

        // Async reset between edges in SETTLE, then a clean sequence.
        do_reset(1'b1);
        add(4,  1, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(13, 1, SETTLE,    1, 0, 1, 0, 2'd0, 4'd0);
        add(20, 1, SETTLE,    1, 0, 1, 0, 2'd0, 4'd0);
        run_table("pre_async");
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(pack(HOLD_PLL, 0, 0, 0, 0, 2'd0, 4'd0));
        check("async_rst_immediate", obs());
        @(posedge clk);
        #1;
        exp_q.push_back(pack(HOLD_PLL, 0, 0, 0, 0, 2'd0, 4'd0));
        check("async_rst_held", obs());
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        add(0,  1, HOLD_PLL,  0, 0, 0, 0, 2'd0, 4'd0);
        add(4,  1, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(12, 1, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(13, 1, SETTLE,    1, 0, 1, 0, 2'd0, 4'd0);
        add(28, 1, SETTLE,    1, 0, 1, 0, 2'd0, 4'd0);
        add(29, 1, RUN,       1, 1, 1, 0, 2'd0, 4'd0);
        run_table("post_async");

        // No lock ever: two retries, then FAULT on the third timeout.
        do_reset(1'b0);
        add(0,   0, HOLD_PLL,  0, 0, 0, 0, 2'd0, 4'd0);
        add(104, 0, WAIT_LOCK, 1, 0, 0, 0, 2'd0, 4'd0);
        add(105, 0, HOLD_PLL,  0, 0, 0, 0, 2'd1, 4'd0);
        add(108, 0, HOLD_PLL,  0, 0, 0, 0, 2'd1, 4'd0);
        add(109, 0, WAIT_LOCK, 1, 0, 0, 0, 2'd1, 4'd0);
        add(209, 0, WAIT_LOCK, 1, 0, 0, 0, 2'd1, 4'd0);
        add(210, 0, HOLD_PLL,  0, 0, 0, 0, 2'd2, 4'd0);
        add(213, 0, HOLD_PLL,  0, 0, 0, 0, 2'd2, 4'd0);
        add(214, 0, WAIT_LOCK, 1, 0, 0, 0, 2'd2, 4'd0);
        add(314, 0, WAIT_LOCK, 1, 0, 0, 0, 2'd2, 4'd0);
        add(315, 0, FAULT,     0, 0, 0, 1, 2'd2, 4'd0);
        run_table("no_lock");

        // FAULT is terminal: random lock activity must not move it for 1000 cycles.
        for (int i = 0; i < 1000; i++) begin
            bus.pll_lock = 1'($urandom_range(0, 1));
            goto(cyc + 1);
            exp_q.push_back(pack(FAULT, 0, 0, 0, 1, 2'd2, 4'd0));
            check($sformatf("fault_hold@%0d", cyc), obs());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
